// File: rtl/reg_bank_pkg.sv
// Shared constants and helpers for the reg_bank_nx register file.
package reg_bank_pkg;

   localparam logic [31:0] PC_RESET_VAL = 32'h0000_1000;
   localparam logic [31:0] SP_RESET_VAL = 32'h03FF_FFFF;
   localparam int          SP_IDX       = 29;

   // Address width for a bank of n words; never narrower than one bit.
   function automatic int addr_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/reg_bank_nx_word.sv
// Single storage word of reg_bank_nx: load-enabled register with a per-word reset value.
module reg_word #(
   parameter int               WIDTH   = 32,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             ld_en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (ld_en) data_d = d;
   end

   // Each bit resets to its own RST_VAL bit, so the preset word needs no extra mux.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) data_q <= RST_VAL;
      else        data_q <= data_d;
   end

   assign q = data_q;

endmodule

// File: rtl/reg_bank_nx.sv
// Multi-port register file: two combinational read ports, one write port, preset word,
// per-word written-since-reset flags. Optional write-through forwarding: REG_BANK_BYPASS_EN.
module reg_bank_nx
   import reg_bank_pkg::*;
#(
   parameter int               WIDTH      = 32,
   parameter int               NUM_REGS   = 32,
   localparam int              ADDR_W     = addr_w(NUM_REGS),
   parameter int               ZERO_REG0  = 1,
   parameter int               PRESET_IDX = SP_IDX,
   parameter logic [WIDTH-1:0] PRESET_VAL = WIDTH'(SP_RESET_VAL)
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                WE,
   input  logic [ADDR_W-1:0]   WADDR,
   input  logic [WIDTH-1:0]    WDATA,
   input  logic [ADDR_W-1:0]   RADDR1,
   output logic [WIDTH-1:0]    RDATA1,
   input  logic [ADDR_W-1:0]   RADDR2,
   output logic [WIDTH-1:0]    RDATA2,
   output logic [NUM_REGS-1:0] VALID
);

   localparam logic [NUM_REGS-1:0] VALID_RST =
      (NUM_REGS'(1) << PRESET_IDX) | ((ZERO_REG0 != 0) ? NUM_REGS'(1) : '0);

   if ((ZERO_REG0 != 0) && (PRESET_IDX == 0)) begin : g_bad_preset
      $error("reg_bank_nx: PRESET_IDX 0 collides with the hardwired zero word");
   end

   logic [NUM_REGS-1:0] wr_sel;
   logic [WIDTH-1:0]    word_q [NUM_REGS];
   logic [NUM_REGS-1:0] valid_q;
   logic [NUM_REGS-1:0] valid_d;

   always_comb begin
      wr_sel = '0;
      if (WE) wr_sel[WADDR] = 1'b1;
      if (ZERO_REG0 != 0) wr_sel[0] = 1'b0;
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_word
      localparam logic [WIDTH-1:0] RV = (g == PRESET_IDX) ? PRESET_VAL : '0;
      reg_word #(
         .WIDTH   (WIDTH),
         .RST_VAL (RV)
      ) u_word (
         .CLK   (CLK),
         .RESET (RESET),
         .ld_en (wr_sel[g]),
         .d     (WDATA),
         .q     (word_q[g])
      );
   end

   // Bit 0 never sees a write select when hardwired, so it stays at its reset value of 1.
   always_comb begin
      valid_d = valid_q | wr_sel;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) valid_q <= VALID_RST;
      else        valid_q <= valid_d;
   end

   assign VALID = valid_q;

   logic fwd_ok;
   assign fwd_ok = WE && !((ZERO_REG0 != 0) && (WADDR == '0));

   always_comb begin
      RDATA1 = word_q[RADDR1];
      RDATA2 = word_q[RADDR2];
      if ((ZERO_REG0 != 0) && (RADDR1 == '0)) RDATA1 = '0;
      if ((ZERO_REG0 != 0) && (RADDR2 == '0)) RDATA2 = '0;
`ifdef REG_BANK_BYPASS_EN
      if (fwd_ok && (WADDR == RADDR1)) RDATA1 = WDATA;
      if (fwd_ok && (WADDR == RADDR2)) RDATA2 = WDATA;
`endif
   end

`ifndef REG_BANK_BYPASS_EN
   logic unused_fwd;
   assign unused_fwd = fwd_ok;
`endif

endmodule

// File: tb/tb_reg_bank_nx.sv
// Directed bench for reg_bank_nx: default 32x32 bank plus a 16-bit, 8-word instance.
module tb_reg_bank_nx;

   logic        CLK;
   logic        RESET;

   logic        we_a;
   logic [4:0]  waddr_a, raddr1_a, raddr2_a;
   logic [31:0] wdata_a, rdata1_a, rdata2_a, valid_a;

   logic        we_b;
   logic [2:0]  waddr_b, raddr1_b, raddr2_b;
   logic [15:0] wdata_b, rdata1_b, rdata2_b;
   logic [7:0]  valid_b;

   int vectors = 0;
   int miscompares = 0;

   reg_bank_nx u_a (
      .CLK    (CLK),
      .RESET  (RESET),
      .WE     (we_a),
      .WADDR  (waddr_a),
      .WDATA  (wdata_a),
      .RADDR1 (raddr1_a),
      .RDATA1 (rdata1_a),
      .RADDR2 (raddr2_a),
      .RDATA2 (rdata2_a),
      .VALID  (valid_a)
   );

   reg_bank_nx #(
      .WIDTH      (16),
      .NUM_REGS   (8),
      .PRESET_IDX (7),
      .PRESET_VAL (16'h0FFF)
   ) u_b (
      .CLK    (CLK),
      .RESET  (RESET),
      .WE     (we_b),
      .WADDR  (waddr_b),
      .WDATA  (wdata_b),
      .RADDR1 (raddr1_b),
      .RDATA1 (rdata1_b),
      .RADDR2 (raddr2_b),
      .RDATA2 (rdata2_b),
      .VALID  (valid_b)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic write_a(input logic [4:0] a, input logic [31:0] d);
      @(negedge CLK);
      we_a = 1'b1; waddr_a = a; wdata_a = d;
      @(posedge CLK); #1;
      we_a = 1'b0;
   endtask

   logic [15:0] bexp;

   initial begin
      RESET = 1'b1;
      we_a = 1'b0; waddr_a = '0; wdata_a = '0; raddr1_a = '0; raddr2_a = '0;
      we_b = 1'b0; waddr_b = '0; wdata_b = '0; raddr1_b = '0; raddr2_b = '0;

      // asynchronous reset pulse, mid-cycle
      repeat (2) @(posedge CLK);
      #3 RESET = 1'b0;
      raddr1_a = 5'd29; raddr2_a = 5'd5;
      raddr1_b = 3'd7;  raddr2_b = 3'd3;
      #1;
      chk("rst_sp",      rdata1_a, 32'h03FF_FFFF);
      chk("rst_w5",      rdata2_a, 32'h0);
      chk("rst_valid",   valid_a,  32'h2000_0001);
      chk("rst_b_w7",    {16'h0, rdata1_b}, 32'h0000_0FFF);
      chk("rst_b_w3",    {16'h0, rdata2_b}, 32'h0);
      chk("rst_b_valid", {24'h0, valid_b},  32'h0000_0081);
      @(negedge CLK);
      RESET = 1'b1;

      // write then read
      raddr1_a = 5'd7; raddr2_a = 5'd29;
      write_a(5'd7, 32'hDEAD_BEEF);
      chk("wr7_rd1",   rdata1_a, 32'hDEAD_BEEF);
      chk("wr7_sp",    rdata2_a, 32'h03FF_FFFF);
      chk("wr7_valid", valid_a,  32'h2000_0081);
      raddr2_a = 5'd7; #1;
      chk("dual_same", rdata2_a, 32'hDEAD_BEEF);

      // hardwired zero word
      raddr1_a = 5'd0;
      write_a(5'd0, 32'hFFFF_FFFF);
      chk("zero_rd",    rdata1_a, 32'h0);
      chk("zero_valid", valid_a,  32'h2000_0081);

      // same-cycle read-after-write
      write_a(5'd3, 32'h0000_1111);
      @(negedge CLK);
      raddr2_a = 5'd3; we_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'h0000_2222;
      #1;
`ifdef REG_BANK_BYPASS_EN
      chk("raw_same", rdata2_a, 32'h0000_2222);
`else
      chk("raw_same", rdata2_a, 32'h0000_1111);
`endif
      @(posedge CLK); #1;
      we_a = 1'b0;
      chk("raw_after", rdata2_a, 32'h0000_2222);
      chk("raw_valid", valid_a,  32'h2000_0089);

      // reset mid-operation
      raddr1_a = 5'd12; raddr2_a = 5'd7;
      write_a(5'd12, 32'h0000_AAAA);
      chk("w12_rd", rdata1_a, 32'h0000_AAAA);
      #2 RESET = 1'b0;
      #1;
      chk("mid_rst_w12",   rdata1_a, 32'h0);
      chk("mid_rst_w7",    rdata2_a, 32'h0);
      chk("mid_rst_valid", valid_a,  32'h2000_0001);
      @(negedge CLK);
      RESET = 1'b1; we_a = 1'b1; waddr_a = 5'd12; wdata_a = 32'h0000_5555;
      @(posedge CLK); #1;
      we_a = 1'b0;
      chk("rel_wr_rd",    rdata1_a, 32'h0000_5555);
      chk("rel_wr_valid", valid_a,  32'h2000_1001);

      // narrow bank: write every address, read back on both ports
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         we_b = 1'b1; waddr_b = 3'(i); wdata_b = 16'hA000 + 16'(i) * 16'h0111;
         @(posedge CLK); #1;
         we_b = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
         raddr1_b = 3'(i); raddr2_b = 3'(7 - i);
         #1;
         bexp = (i == 0) ? 16'h0 : 16'hA000 + 16'(i) * 16'h0111;
         chk($sformatf("b_rd1_%0d", i), {16'h0, rdata1_b}, {16'h0, bexp});
         bexp = (i == 7) ? 16'h0 : 16'hA000 + 16'(7 - i) * 16'h0111;
         chk($sformatf("b_rd2_%0d", 7 - i), {16'h0, rdata2_b}, {16'h0, bexp});
      end
      chk("b_valid_all", {24'h0, valid_b}, 32'h0000_00FF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
